// File: rtl/led_scan_pkg.sv
// Shared types and constants for the LED scan arbiter.
// State enum, decoder enable codes, LED idle pattern, requester count.
package led_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1
`ifdef LED_SCAN_BLANK_EN
    ,
    ST_BLANK = 2'd2
`endif
  } state_t;

  localparam int         NUM_REQ     = 8;
  localparam logic [2:0] ENABLE_ON   = 3'b100;
  localparam logic [2:0] ENABLE_OFF  = 3'b000;
  localparam logic [7:0] LED_ALL_OFF = 8'hff;

  // Active-low one-hot pattern for one decoder line.
  function automatic logic [7:0] led_for(
    input logic [2:0] id
  );
    return ~(8'h01 << id);
  endfunction

endpackage

// File: rtl/led_scan_arbiter_rr_pick.sv
// Combinational rotating-priority encoder.
// Ports: req[7:0], ptr[2:0] in; winner[2:0] (first set bit at or after ptr), any out.
module rr_pick
  import led_scan_pkg::*;
(
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  output logic [2:0] winner,
  output logic       any
);

  logic [2:0] idx;

  // Scan from farthest to nearest so the nearest hit is written last.
  always_comb begin
    winner = ptr;
    any    = |req;
    idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + 3'(k);
      if (req[idx]) begin
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/led_scan_arbiter.sv
// Round-robin arbiter time-sharing one 3-to-8 LED decoder among 8 requesters.
// Ports: clk, rst (async high), req[7:0], dwell; registered switch, enable, led, busy, slot_done.
// Optional LED_SCAN_BLANK_EN inserts one dark cycle after every grant.
module led_scan_arbiter
  import led_scan_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         req,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         switch,
  output logic [2:0]         enable,
  output logic [7:0]         led,
  output logic               busy,
  output logic               slot_done
);

  state_t state_q, state_d;

  logic [2:0]         ptr_q, ptr_d;
  logic [2:0]         switch_q, switch_d;
  logic [2:0]         enable_q, enable_d;
  logic [7:0]         led_q, led_d;
  logic               busy_q, busy_d;
  logic               slot_done_q, slot_done_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;

  logic       start;
  logic       last;
  logic       grant_d;
  logic [2:0] pick_ptr;
  logic [2:0] winner;
  logic       any;

  // A back-to-back grant must already see the pointer
  // advanced past the requester just finishing.
  assign pick_ptr = (state_q == ST_GRANT) ? switch_q + 3'd1 : ptr_q;
  assign last     = (state_q == ST_GRANT) && (cnt_q == dwell_q);

  rr_pick u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .winner (winner),
    .any    (any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      switch_q    <= '0;
      enable_q    <= ENABLE_OFF;
      led_q       <= LED_ALL_OFF;
      busy_q      <= 1'b0;
      slot_done_q <= 1'b0;
      dwell_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      switch_q    <= switch_d;
      enable_q    <= enable_d;
      led_q       <= led_d;
      busy_q      <= busy_d;
      slot_done_q <= slot_done_d;
      dwell_q     <= dwell_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (any) begin
          state_d = ST_GRANT;
          start   = 1'b1;
        end
      end
      ST_GRANT: begin
        if (last) begin
`ifdef LED_SCAN_BLANK_EN
          state_d = ST_BLANK;
`else
          if (any) begin
            state_d = ST_GRANT;
            start   = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
`endif
        end
      end
`ifdef LED_SCAN_BLANK_EN
      ST_BLANK: begin
        if (any) begin
          state_d = ST_GRANT;
          start   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are computed one cycle ahead and registered,
  // so nothing reaches a port combinationally.
  always_comb begin
    ptr_d    = ptr_q;
    switch_d = switch_q;
    dwell_d  = dwell_q;
    cnt_d    = cnt_q;
    if (last) begin
      ptr_d = switch_q + 3'd1;
    end
    if (start) begin
      switch_d = winner;
      dwell_d  = dwell;
      cnt_d    = '0;
    end else if (state_d == ST_GRANT) begin
      cnt_d = cnt_q + DWELL_W'(1);
    end
    grant_d     = (state_d == ST_GRANT);
    enable_d    = grant_d ? ENABLE_ON : ENABLE_OFF;
    led_d       = grant_d ? led_for(switch_d) : LED_ALL_OFF;
    busy_d      = grant_d;
    slot_done_d = grant_d && (cnt_d == dwell_d);
  end

  assign switch    = switch_q;
  assign enable    = enable_q;
  assign led       = led_q;
  assign busy      = busy_q;
  assign slot_done = slot_done_q;

endmodule

// File: doc/led_scan_arbiter.md
LED_SCAN_ARBITER -- requirements
Module: led_scan_arbiter

Interface
REQ-001 Parameter DWELL_W, default 4, width of the dwell-length input.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  8  per-requester request, bit i asks for decoder line i.
REQ-005 dwell  input  DWELL_W  grant length minus one, in clk cycles.
REQ-006 switch  output  3  registered decoder select (granted requester id).
REQ-007 enable  output  3  registered decoder enable: 3'b100 while a grant is active, 3'b000 otherwise.
REQ-008 led  output  8  registered active-low one-hot: ~(1<<switch) while granted, 8'hff otherwise.
REQ-009 busy  output  1  high in every cycle a grant is active.
REQ-010 slot_done  output  1  one-cycle pulse in the last cycle of each grant.

Function
REQ-011 States: IDLE, GRANT, and BLANK (BLANK only when LED_SCAN_BLANK_EN is defined).
REQ-012 IDLE: all outputs inactive; when req != 0, next edge enters GRANT with the round-robin winner; latency exactly 1 cycle from req sampled to enable=3'b100.
REQ-013 Round-robin winner: first set req bit searching upward from pointer ptr, wrapping 7->0.
REQ-014 At grant start: switch=winner, enable=3'b100, led=~(8'h01<<winner), busy=1, dwell captured into internal register, counter cleared to 0.
REQ-015 GRANT lasts captured dwell+1 cycles; dwell=0 gives a 1-cycle grant; dwell changes during a grant have no effect.
REQ-016 Grants are non-preemptive: deasserting the granted req bit mid-grant does not shorten the grant.
REQ-017 slot_done=1 in the final GRANT cycle only; ptr updates to (winner+1) mod 8 on the following edge (7 wraps to 0).
REQ-018 End of grant without BLANK: if req != 0, next grant starts on the very next cycle (back-to-back, no gap); else enter IDLE.
REQ-019 switch holds its last value when enable=3'b000; led is 8'hff whenever enable != 3'b100.
REQ-020 Single requester held high: re-granted continuously, each grant dwell+1 cycles, slot_done once per grant.
REQ-021 No combinational path from any input to any output.

Reset
REQ-022 rst asserted: immediately state=IDLE, ptr=0, switch=3'd0, enable=3'b000, led=8'hff, busy=0, slot_done=0, counter=0.
REQ-023 rst asserted mid-grant aborts the grant with no slot_done pulse; rst dominates all simultaneous events.
REQ-024 First grant after reset release searches from requester 0.

Configuration
REQ-025 Macro LED_SCAN_BLANK_EN defined: after every GRANT, exactly one BLANK cycle (enable=3'b000, led=8'hff, busy=0), then GRANT if req != 0 else IDLE.
REQ-026 Macro undefined: BLANK state absent, behaviour per REQ-018.

Structure
REQ-027 Package led_scan_pkg holds: state enum type, ENABLE_ON=3'b100, ENABLE_OFF=3'b000, LED_ALL_OFF=8'hff, NUM_REQ=8.
REQ-028 One sub-module rr_pick: combinational rotating-priority encoder (inputs req[7:0], ptr[2:0]; outputs winner[2:0], any); all registers live in led_scan_arbiter.

Verification
REQ-029 Reset then req=8'h00 for 10 cycles -> led=8'hff, enable=3'b000, busy=0 throughout.
REQ-030 dwell=2, req=8'h08 from cycle 0 -> cycle 1 switch=3, led=8'hf7, enable=3'b100 for 3 cycles, slot_done on third, then immediate re-grant to 3 (no BLANK build).
REQ-031 dwell=0, req=8'hff -> grants 0,1,2,...,7,0 on consecutive cycles, led walking 8'hfe,8'hfd,...,8'h7f,8'hfe.
REQ-032 ptr=7 after grant to 6, req=8'h81 -> next grant 7, then 0 (wrap-around).
REQ-033 dwell=5, req=8'h04, rst pulsed in 3rd grant cycle -> outputs return to 8'hff/3'b000 immediately, no slot_done, next grant starts from search at 0.
REQ-034 LED_SCAN_BLANK_EN defined, dwell=1, req=8'h03 -> grant 0 (2 cycles), 1 blank cycle led=8'hff, grant 1 (2 cycles), blank, grant 0.
